// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, arbiter state encoding and read-tag type for the SRAM arbiter
package sram_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 17;
  localparam int SRAM_READ_LATENCY = 4;
  typedef enum logic {ARB, TURN} arb_state_e;
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;
endpackage

// File: rtl/sram_port_if.sv
// sram_port_if: one requester's handshake, command fields and read return
interface sram_port_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_read_tag_pipe.sv
// sram_read_tag_pipe: {valid, port} delay line aligned to SRAM read latency, demuxes
// returned data into the owning port's registered rdata/rvalid
module sram_read_tag_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH = SRAM_READ_LATENCY,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  tag_t              tag_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);
  tag_t pipe_q [DEPTH];
  tag_t tail;
  logic [1:0] rvalid_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  assign tail = pipe_q[DEPTH-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      rvalid_q <= {tail.valid & tail.port, tail.valid & ~tail.port};
      if (tail.valid & ~tail.port) rdata0_q <= rdata_i;
      if (tail.valid & tail.port) rdata1_q <= rdata_i;
    end
  end
  assign rvalid_o = rvalid_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter for a single SRAM port with registered command bus,
// read-to-write turnaround and tagged read return
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int READ_LATENCY = SRAM_READ_LATENCY,
  parameter int TURNAROUND = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_if.slave        p0,
  sram_port_if.slave        p1,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam int CNT_W = TURNAROUND > 1 ? $clog2(TURNAROUND) : 1;
  arb_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic ptr_q, last_rd_q, mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  tag_t tag_q;
  logic any, win, win_we, stall, grant;
  logic [1:0] rvalid;
  assign any = p0.req | p1.req;
  assign win = (p0.req & p1.req) ? (FIXED_PRIORITY != 0 ? 1'b0 : ptr_q) : p1.req;
  assign win_we = win ? p1.we : p0.we;
  // a write right behind an issued read must wait out the bus turnaround
  assign stall = win_we & last_rd_q & (TURNAROUND > 0);
  assign grant = (state_q == ARB) & any & ~stall;
  assign p0.gnt = grant & ~win;
  assign p1.gnt = grant & win;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      cnt_q <= '0;
      ptr_q <= 1'b0;
      last_rd_q <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      tag_q <= '0;
    end else begin
      mem_we_q <= grant & win_we;
      last_rd_q <= grant & ~win_we;
      tag_q <= '{valid: grant & ~win_we, port: win};
      if (grant) begin
        ptr_q <= ~win;
        addr_q <= win ? p1.addr : p0.addr;
        wdata_q <= win ? p1.wdata : p0.wdata;
      end
      // the stalled ARB cycle is the first idle cycle; TURN covers the rest
      if (state_q == ARB) begin
        if (any && stall && TURNAROUND > 1) begin
          state_q <= TURN;
          cnt_q <= CNT_W'(TURNAROUND - 1);
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_q <= ARB;
      end
    end
  end
  assign mem_we_o = mem_we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  sram_read_tag_pipe #(.DEPTH(READ_LATENCY), .DATA_W(DATA_W)) u_tag_pipe (
    .clk(clk),
    .rst(rst),
    .tag_i(tag_q),
    .rdata_i(mem_rdata_i),
    .rvalid_o(rvalid),
    .rdata0_o(p0.rdata),
    .rdata1_o(p1.rdata)
  );
  assign p0.rvalid = rvalid[0];
  assign p1.rvalid = rvalid[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: three configurations (default, no turnaround, fixed priority) against a rule-level reference model
module tb_sram_arbiter;
  import sram_pkg::*;
  typedef struct {
    logic we;
    logic [19:0] addr;
    logic [16:0] wdata;
    int idle;
  } txn_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic req [3][2];
  logic we [3][2];
  logic [19:0] addr [3][2];
  logic [16:0] wdata [3][2];
  wire gnt [3][2];
  wire rv [3][2];
  wire [16:0] rd [3][2];
  wire mwe [3];
  wire [19:0] maddr [3];
  wire [16:0] mwd [3];
  logic [16:0] mrd [3];
  generate
    for (genvar k = 0; k < 3; k++) begin : g
      sram_port_if a ();
      sram_port_if b ();
      assign a.req = req[k][0];
      assign a.we = we[k][0];
      assign a.addr = addr[k][0];
      assign a.wdata = wdata[k][0];
      assign b.req = req[k][1];
      assign b.we = we[k][1];
      assign b.addr = addr[k][1];
      assign b.wdata = wdata[k][1];
      assign gnt[k][0] = a.gnt;
      assign gnt[k][1] = b.gnt;
      assign rv[k][0] = a.rvalid;
      assign rv[k][1] = b.rvalid;
      assign rd[k][0] = a.rdata;
      assign rd[k][1] = b.rdata;
      sram_arbiter #(.TURNAROUND(k == 1 ? 0 : 1), .FIXED_PRIORITY(k == 2 ? 1 : 0)) dut (
        .clk(clk),
        .rst(rst),
        .p0(a),
        .p1(b),
        .mem_we_o(mwe[k]),
        .mem_addr_o(maddr[k]),
        .mem_wdata_o(mwd[k]),
        .mem_rdata_i(mrd[k])
      );
    end
  endgenerate
  int total = 0, bad = 0, cyc = 0;
  int fav [3];
  bit prev_rd [3];
  int idle_left [3];
  logic ebw [3];
  logic [19:0] eba [3];
  logic [16:0] ebd [3];
  logic [16:0] erd [3][2];
  bit sv [3][8];
  bit sp [3][8];
  logic [16:0] sd [3][8];
  logic [16:0] hist [3][5];
  logic [16:0] smem [int];
  logic [16:0] rmem [int];
  int ptr [3][2];
  int wcnt [3][2];
  bit xfer [3][2];
  int rv_cnt [3][2];
  txn_t tx0 [$];
  txn_t tx1 [$];
  function automatic int key(int k, logic [19:0] a);
    return k * (1 << 20) + int'(a);
  endfunction
  function automatic logic [16:0] dflt(logic [19:0] a);
    return a[16:0] ^ 17'h15A5A;
  endfunction
  function automatic int tsz(int p);
    return p != 0 ? tx1.size() : tx0.size();
  endfunction
  function automatic txn_t get_tx(int p, int i);
    return p != 0 ? tx1[i] : tx0[i];
  endfunction
  function automatic int ta(int k);
    return k == 1 ? 0 : 1;
  endfunction
  // SRAM model, reference arbiter/return model and per-cycle scoreboard
  always @(negedge clk) begin
    int w, s;
    bit g, any;
    logic [16:0] v;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      for (int i = 4; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = smem.exists(key(k, maddr[k])) ? smem[key(k, maddr[k])] : dflt(maddr[k]);
      if (mwe[k] === 1'b1) smem[key(k, maddr[k])] = mwd[k];
      mrd[k] = hist[k][4];
      if (rst) begin
        fav[k] = 0; prev_rd[k] = 0; idle_left[k] = 0;
        ebw[k] = 0; eba[k] = 0; ebd[k] = 0;
        for (int p = 0; p < 2; p++) begin erd[k][p] = 0; xfer[k][p] = 0; end
        for (int i = 0; i < 8; i++) sv[k][i] = 0;
      end else begin
        any = req[k][0] || req[k][1];
        w = (req[k][0] && req[k][1]) ? (k == 2 ? 0 : fav[k]) : (req[k][1] ? 1 : 0);
        if (idle_left[k] > 0) begin
          g = 0;
          idle_left[k]--;
        end else if (any && we[k][w] && prev_rd[k] && ta(k) > 0) begin
          g = 0;
          idle_left[k] = ta(k) - 1;
        end else g = any;
        for (int p = 0; p < 2; p++) begin
          total++;
          if (gnt[k][p] !== (g && w == p)) begin
            bad++;
            $display("FAIL gnt k%0d p%0d cyc%0d: got %b want %b", k, p, cyc, gnt[k][p], g && w == p);
          end
        end
        total++;
        if ({mwe[k], maddr[k], mwd[k]} !== {ebw[k], eba[k], ebd[k]}) begin
          bad++;
          $display("FAIL bus k%0d cyc%0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                   k, cyc, mwe[k], maddr[k], mwd[k], ebw[k], eba[k], ebd[k]);
        end
        s = cyc % 8;
        for (int p = 0; p < 2; p++) begin
          if (sv[k][s] && sp[k][s] == p) erd[k][p] = sd[k][s];
          total++;
          if (rv[k][p] !== (sv[k][s] && sp[k][s] == p)) begin
            bad++;
            $display("FAIL rvalid k%0d p%0d cyc%0d: got %b want %b", k, p, cyc, rv[k][p], sv[k][s] && sp[k][s] == p);
          end
          total++;
          if (rd[k][p] !== erd[k][p]) begin
            bad++;
            $display("FAIL rdata k%0d p%0d cyc%0d: got %h want %h", k, p, cyc, rd[k][p], erd[k][p]);
          end
          if (rv[k][p] === 1'b1) rv_cnt[k][p]++;
        end
        sv[k][s] = 0;
        if (g) begin
          ebw[k] = we[k][w]; eba[k] = addr[k][w]; ebd[k] = wdata[k][w];
          prev_rd[k] = !we[k][w];
          fav[k] = 1 - w;
          xfer[k][w] = 1;
          if (we[k][w]) rmem[key(k, addr[k][w])] = wdata[k][w];
          else begin
            v = rmem.exists(key(k, addr[k][w])) ? rmem[key(k, addr[k][w])] : dflt(addr[k][w]);
            s = (cyc + 6) % 8;
            sv[k][s] = 1; sp[k][s] = w[0]; sd[k][s] = v;
          end
        end else begin
          ebw[k] = 0;
          prev_rd[k] = 0;
        end
      end
    end
  end
  // requester drivers: hold each transaction until its grant, optional idle gap before the next
  always @(posedge clk) begin
    txn_t t;
    #1;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        if (xfer[k][p]) begin
          xfer[k][p] = 0;
          ptr[k][p]++;
          wcnt[k][p] = ptr[k][p] < tsz(p) ? get_tx(p, ptr[k][p]).idle : 0;
        end else if (!req[k][p] && wcnt[k][p] > 0) wcnt[k][p]--;
        req[k][p] = !rst && ptr[k][p] < tsz(p) && wcnt[k][p] == 0;
        if (ptr[k][p] < tsz(p)) begin
          t = get_tx(p, ptr[k][p]);
          we[k][p] = t.we; addr[k][p] = t.addr; wdata[k][p] = t.wdata;
        end
      end
  end
  task automatic push(int p, logic w, logic [19:0] a, logic [16:0] d, int idle);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d; t.idle = idle;
    if (p != 0) tx1.push_back(t); else tx0.push_back(t);
  endtask
  task automatic drain(string name);
    int n = 0;
    bit busy;
    do begin
      @(posedge clk);
      #2;
      busy = 0;
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) busy |= ptr[k][p] < tsz(p) || req[k][p];
        for (int i = 0; i < 8; i++) busy |= sv[k][i];
      end
      n++;
    end while (busy && n < 3000);
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (busy) begin
      bad++;
      $display("FAIL drain %s: still busy after %0d cycles, want idle", name, n);
    end
  endtask
  task automatic test_reset();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 0; we[k][p] = 0; addr[k][p] = 0; wdata[k][p] = 0;
        ptr[k][p] = 0; wcnt[k][p] = 0; xfer[k][p] = 0; rv_cnt[k][p] = 0;
      end
    rst = 1;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({mwe[k], maddr[k], mwd[k]} !== 38'd0) begin
        bad++;
        $display("FAIL reset_bus k%0d: got we=%b a=%h d=%h want 0", k, mwe[k], maddr[k], mwd[k]);
      end
      for (int p = 0; p < 2; p++) begin
        total++;
        if ({rv[k][p], rd[k][p], gnt[k][p]} !== 19'd0) begin
          bad++;
          $display("FAIL reset_port k%0d p%0d: got rv=%b rd=%h gnt=%b want 0", k, p, rv[k][p], rd[k][p], gnt[k][p]);
        end
      end
    end
    @(posedge clk);
    #3 rst = 0;
  endtask
  task automatic test_read_latency();
    int c0 [3];
    for (int k = 0; k < 3; k++) c0[k] = rv_cnt[k][0];
    push(0, 0, 20'h00010, 0, 0);
    drain("read_latency");
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rv_cnt[k][0] - c0[k] !== 1 || rd[k][0] !== 17'h1ABCD) begin
        bad++;
        $display("FAIL read_latency k%0d: got pulses=%0d rd=%h want 1 and 1abcd", k, rv_cnt[k][0] - c0[k], rd[k][0]);
      end
    end
  endtask
  task automatic test_round_robin();
    int c0 [3][2];
    for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) c0[k][p] = rv_cnt[k][p];
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 20'h00040 + 20'(i), 0, 0);
      push(1, 0, 20'h00080 + 20'(i), 0, 0);
    end
    drain("round_robin");
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        total++;
        if (rv_cnt[k][p] - c0[k][p] !== 4) begin
          bad++;
          $display("FAIL rr_count k%0d p%0d: got %0d want 4", k, p, rv_cnt[k][p] - c0[k][p]);
        end
      end
  endtask
  task automatic test_turnaround();
    push(0, 0, 20'h00123, 0, 0);
    push(0, 1, 20'h00123, 17'h0BEEF, 0);
    push(0, 0, 20'h00123, 0, 0);
    push(1, 1, 20'h00200, 17'h13579, 0);
    drain("turnaround");
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd[k][0] !== 17'h0BEEF) begin
        bad++;
        $display("FAIL turnaround_rd k%0d: got %h want 0beef", k, rd[k][0]);
      end
    end
  endtask
  task automatic test_priority();
    int c0 [3][2];
    for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) c0[k][p] = rv_cnt[k][p];
    for (int i = 0; i < 5; i++) push(0, 0, 20'h00300 + 20'(i), 0, 0);
    push(1, 0, 20'h00400, 0, 0);
    drain("priority");
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rv_cnt[k][0] - c0[k][0] !== 5 || rv_cnt[k][1] - c0[k][1] !== 1) begin
        bad++;
        $display("FAIL priority_count k%0d: got %0d/%0d want 5/1", k, rv_cnt[k][0] - c0[k][0], rv_cnt[k][1] - c0[k][1]);
      end
    end
  endtask
  task automatic test_write_read();
    int c0 [3][2];
    for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) c0[k][p] = rv_cnt[k][p];
    push(1, 1, 20'hFFFFF, 17'h0FFFF, 0);
    push(1, 0, 20'hFFFFF, 0, 0);
    drain("write_read");
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rd[k][1] !== 17'h0FFFF || rv_cnt[k][1] - c0[k][1] !== 1 || rv_cnt[k][0] != c0[k][0]) begin
        bad++;
        $display("FAIL write_read k%0d: got rd=%h p1=%0d p0=%0d want 0ffff 1 0",
                 k, rd[k][1], rv_cnt[k][1] - c0[k][1], rv_cnt[k][0] - c0[k][0]);
      end
    end
  endtask
  task automatic test_random();
    int c0 [3][2];
    int nrd [2];
    bit w;
    for (int k = 0; k < 3; k++) for (int p = 0; p < 2; p++) c0[k][p] = rv_cnt[k][p];
    nrd[0] = 0; nrd[1] = 0;
    for (int i = 0; i < 150; i++)
      for (int p = 0; p < 2; p++) begin
        w = 1'($urandom_range(0, 1));
        if (!w) nrd[p]++;
        push(p, w, 20'h00500 + 20'($urandom_range(0, 7)), 17'($urandom), $urandom_range(0, 2));
      end
    drain("random");
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        total++;
        if (rv_cnt[k][p] - c0[k][p] !== nrd[p]) begin
          bad++;
          $display("FAIL random_count k%0d p%0d: got %0d want %0d", k, p, rv_cnt[k][p] - c0[k][p], nrd[p]);
        end
      end
  endtask
  task automatic test_reset_midstream();
    int n = 0, inflight = 0;
    int c0 [3][2];
    for (int i = 0; i < 3; i++) push(0, 0, 20'h00600 + 20'(i), 0, 0);
    do begin
      @(posedge clk);
      #2;
      inflight = 0;
      for (int i = 0; i < 8; i++) inflight += int'(sv[0][i]);
      n++;
    end while (inflight < 3 && n < 40);
    total++;
    if (inflight < 3) begin
      bad++;
      $display("FAIL midreset_inflight: got %0d want 3", inflight);
    end
    #1 rst = 1;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 0; ptr[k][p] = tsz(p); wcnt[k][p] = 0; xfer[k][p] = 0;
        c0[k][p] = rv_cnt[k][p];
      end
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({mwe[k], maddr[k], mwd[k], rv[k][0], rv[k][1], rd[k][0], rd[k][1]} !== 74'd0) begin
        bad++;
        $display("FAIL midreset_zero k%0d: got we=%b a=%h d=%h rv=%b%b rd=%h/%h want 0",
                 k, mwe[k], maddr[k], mwd[k], rv[k][0], rv[k][1], rd[k][0], rd[k][1]);
      end
    end
    repeat (2) @(posedge clk);
    #3 rst = 0;
    repeat (10) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        total++;
        if (rv_cnt[k][p] != c0[k][p]) begin
          bad++;
          $display("FAIL midreset_spurious k%0d p%0d: got %0d pulses want 0", k, p, rv_cnt[k][p] - c0[k][p]);
        end
      end
    push(0, 0, 20'h00700, 0, 0);
    push(1, 0, 20'h00701, 0, 0);
    drain("post_reset");
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      smem[key(k, 20'h00010)] = 17'h1ABCD;
      rmem[key(k, 20'h00010)] = 17'h1ABCD;
    end
    test_reset();
    test_read_latency();
    test_round_robin();
    test_turnaround();
    test_priority();
    test_write_read();
    test_random();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
